// File: rtl/tx_pkg.sv
// Shared definitions for the serial transmitter.
//   tx_state_e : frame FSM states
//   DATA_BITS  : data bits per frame
//   FRAME_BITS : total bits per frame (start + data + stop)
package tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  localparam int DATA_BITS  = 8;
  localparam int FRAME_BITS = 10;

endpackage : tx_pkg

// File: rtl/tx_bit_timer.sv
// Bit timing for the serial transmitter.
//   clk, n_rst  : clock, asynchronous active-low reset
//   run         : a frame is on the line; counter idles at 0 otherwise
//   data_phase  : FSM is shifting data bits; bit index counts only here
//   bit_end     : high in the last cycle of every bit period
//   bit_idx     : index of the data bit currently on the line (0..7)
module tx_bit_timer
  import tx_pkg::*;
#(
  parameter int BIT_PERIOD = 10
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       run,
  input  logic       data_phase,
  output logic       bit_end,
  output logic [2:0] bit_idx
);

  // 8 bits covers the full legal BIT_PERIOD range of 2..255.
  logic [7:0] cnt;

  assign bit_end = run && (cnt == 8'(BIT_PERIOD - 1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt <= '0;
    end else if (!run || bit_end) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      bit_idx <= '0;
    end else if (!data_phase) begin
      bit_idx <= '0;
    end else if (bit_end) begin
      // Leaving DATA after the last bit: start the next frame from bit 0.
      bit_idx <= (bit_idx == 3'(DATA_BITS - 1)) ? 3'd0 : bit_idx + 3'd1;
    end
  end

endmodule : tx_bit_timer

// File: rtl/tx_block.sv
// 8N1 serial transmitter with a one-byte holding buffer.
//   clk, n_rst  : clock, asynchronous active-low reset
//   tx_data     : byte to send, captured when tx_valid && tx_ready
//   tx_valid    : producer offers tx_data
//   tx_ready    : holding buffer empty
//   serial_out  : registered serial line, idle high
//   tx_busy     : start, data or stop bit on the line
//   tx_done     : pulse in the last cycle of each stop bit
module tx_block
  import tx_pkg::*;
#(
  parameter int BIT_PERIOD = 10
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       serial_out,
  output logic       tx_busy,
  output logic       tx_done
);

  tx_state_e  state, state_next;
  logic [7:0] buf_data;
  logic       buf_full;
  logic [7:0] shift_q;
  logic       line_next;
  logic       load;
  logic       shift_en;
  logic       bit_end;
  logic [2:0] bit_idx;
  logic       last_bit;

  tx_bit_timer #(.BIT_PERIOD(BIT_PERIOD)) u_timer (
    .clk        (clk),
    .n_rst      (n_rst),
    .run        (state != IDLE),
    .data_phase (state == DATA),
    .bit_end    (bit_end),
    .bit_idx    (bit_idx)
  );

  assign last_bit = (bit_idx == 3'(DATA_BITS - 1));
  assign tx_ready = !buf_full;
  assign tx_busy  = (state != IDLE);
  assign tx_done  = (state == STOP) && bit_end;

  // The line value is computed for the next state so serial_out can be a
  // plain register and still change on the same edge as the FSM.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves it unassigned and no latch is inferred.
    state_next = state;
    line_next  = serial_out;
    load       = 1'b0;
    shift_en   = 1'b0;
    unique case (state)
      IDLE: begin
        line_next = 1'b1;
        if (buf_full) begin
          state_next = START;
          load       = 1'b1;
          line_next  = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          state_next = DATA;
          line_next  = shift_q[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_en = 1'b1;
          if (last_bit) begin
            state_next = STOP;
            line_next  = 1'b1;
          end else begin
            line_next = shift_q[1];
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          // A byte waiting in the buffer starts with no idle gap.
          if (buf_full) begin
            state_next = START;
            load       = 1'b1;
            line_next  = 1'b0;
          end else begin
            state_next = IDLE;
            line_next  = 1'b1;
          end
        end
      end
      default: begin
        state_next = IDLE;
        line_next  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= IDLE;
      serial_out <= 1'b1;
      shift_q    <= '0;
    end else begin
      state      <= state_next;
      serial_out <= line_next;
      if (load) begin
        shift_q <= buf_data;
      end else if (shift_en) begin
        shift_q <= shift_q >> 1;
      end
    end
  end

  // Load only happens while the buffer is full and accept only while it is
  // empty, so the two branches can never compete in one cycle.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      // NOTE: the data byte is reset too; it is a single register, not a
      // memory, and a known value keeps the line deterministic after reset.
      buf_full <= 1'b0;
      buf_data <= '0;
    end else if (load) begin
      buf_full <= 1'b0;
    end else if (tx_valid && tx_ready) begin
      buf_full <= 1'b1;
      buf_data <= tx_data;
    end
  end

endmodule : tx_block

// File: tb/tb_tx_block.sv
// Self-checking bench for tx_block. Two instances (BIT_PERIOD 10 and 16)
// share the stimulus; each is compared every cycle against a frame model
// that derives the line value from the cycle offset inside the frame.
module tb_tx_block;
  import tx_pkg::*;

  logic       clk = 1'b0;
  logic       n_rst;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       rdy0, ser0, busy0, done0;
  logic       rdy1, ser1, busy1, done1;

  always #5 clk = ~clk;

  tx_block #(.BIT_PERIOD(10)) dut0 (
    .clk(clk), .n_rst(n_rst), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(rdy0), .serial_out(ser0), .tx_busy(busy0), .tx_done(done0)
  );

  tx_block #(.BIT_PERIOD(16)) dut1 (
    .clk(clk), .n_rst(n_rst), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(rdy1), .serial_out(ser1), .tx_busy(busy1), .tx_done(done1)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int         per [2];
  bit         m_full [2];
  logic [7:0] m_buf  [2];
  bit         m_act  [2];
  int         m_cyc  [2];
  logic [7:0] m_byte [2];

  int run_len [2];
  int last_run[2];

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_full[i] = 0; m_buf[i] = '0; m_act[i] = 0; m_cyc[i] = 0; m_byte[i] = '0;
      run_len[i] = 0;
    end
  endtask

  task automatic model_step(input int i);
    bit acc;
    acc = tx_valid && !m_full[i];
    if (m_act[i] && m_cyc[i] == FRAME_BITS * per[i] - 1) m_act[i] = 0;
    else if (m_act[i]) m_cyc[i]++;
    if (!m_act[i] && m_full[i]) begin
      m_act[i]  = 1;
      m_cyc[i]  = 0;
      m_byte[i] = m_buf[i];
      m_full[i] = 0;
    end
    if (acc) begin
      m_full[i] = 1;
      m_buf[i]  = tx_data;
    end
  endtask

  function automatic logic exp_line(input int i);
    int k;
    if (!m_act[i]) return 1'b1;
    k = m_cyc[i] / per[i];
    if (k == 0) return 1'b0;
    if (k <= DATA_BITS) return m_byte[i][k-1];
    return 1'b1;
  endfunction

  task automatic compare_all();
    logic s, b, d, r;
    for (int i = 0; i < 2; i++) begin
      s = (i == 0) ? ser0  : ser1;
      b = (i == 0) ? busy0 : busy1;
      d = (i == 0) ? done0 : done1;
      r = (i == 0) ? rdy0  : rdy1;
      check($sformatf("p%0d serial_out", per[i]), 32'(s), 32'(exp_line(i)));
      check($sformatf("p%0d tx_busy", per[i]), 32'(b), 32'(m_act[i]));
      check($sformatf("p%0d tx_done", per[i]), 32'(d),
            32'(m_act[i] && m_cyc[i] == FRAME_BITS * per[i] - 1));
      check($sformatf("p%0d tx_ready", per[i]), 32'(r), 32'(!m_full[i]));
      if (b) run_len[i]++;
      else begin
        if (run_len[i] > 0) last_run[i] = run_len[i];
        run_len[i] = 0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (n_rst) begin
      for (int i = 0; i < 2; i++) model_step(i);
    end else begin
      model_reset();
    end
    #1;
    compare_all();
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic send(input logic [7:0] b);
    tx_valid = 1'b1;
    tx_data  = b;
    tick();
    tx_valid = 1'b0;
    tx_data  = 8'($urandom);
  endtask

  int done_at;
  int done_cnt;

  initial begin
    per[0] = 10;
    per[1] = 16;
    last_run[0] = 0;
    last_run[1] = 0;
    n_rst    = 1'b0;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    model_reset();
    #12;
    compare_all();
    ticks(2);
    n_rst = 1'b1;
    ticks(2);

    // 0xA5 from idle: done lands in frame cycle 100 for BIT_PERIOD=10.
    send(8'hA5);
    done_at = -1;
    for (int k = 1; k <= 170; k++) begin
      tick();
      if (done0 && done_at < 0) done_at = k;
    end
    check("a5 done cycle", 32'(done_at), 32'd100);
    check("a5 frame len p10", 32'(last_run[0]), 32'd100);

    // 0x81 on BIT_PERIOD=16: 160-cycle frame, single-cycle done.
    send(8'h81);
    done_cnt = 0;
    for (int k = 0; k < 170; k++) begin
      tick();
      if (done1) done_cnt++;
    end
    check("81 frame len p16", 32'(last_run[1]), 32'd160);
    check("81 done width p16", 32'(done_cnt), 32'd1);

    // Back-to-back: second byte offered while the first is in DATA.
    send(8'h00);
    ticks(30);
    send(8'hFF);
    ticks(340);
    check("b2b len p10", 32'(last_run[0]), 32'd200);
    check("b2b len p16", 32'(last_run[1]), 32'd320);

    // Buffer full while tx_valid stays high with 0x3C.
    send(8'h11);
    ticks(3);
    send(8'h22);
    tx_valid = 1'b1;
    tx_data  = 8'h3C;
    ticks(60);
    tx_valid = 1'b0;
    ticks(500);

    // Dense random traffic.
    for (int k = 0; k < 3000; k++) begin
      tx_valid = 1'($urandom_range(0, 1));
      tx_data  = 8'($urandom);
      tick();
    end
    tx_valid = 1'b0;
    ticks(400);

    // Reset in cycle 45 of a frame, then a clean frame.
    send(8'hC3);
    ticks(45);
    n_rst = 1'b0;
    #1;
    model_reset();
    check("rst serial_out", 32'(ser0), 32'd1);
    check("rst tx_busy", 32'(busy0), 32'd0);
    check("rst tx_ready", 32'(rdy0), 32'd1);
    check("rst tx_done", 32'(done0), 32'd0);
    compare_all();
    ticks(2);
    n_rst = 1'b1;
    ticks(1);
    send(8'h5A);
    ticks(170);
    check("post-rst len p10", 32'(last_run[0]), 32'd100);
    check("post-rst len p16", 32'(last_run[1]), 32'd160);

    // Sparse random traffic with idle gaps.
    for (int k = 0; k < 2000; k++) begin
      tx_valid = ($urandom_range(0, 7) == 0);
      tx_data  = 8'($urandom);
      tick();
    end
    tx_valid = 1'b0;
    ticks(400);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_tx_block
